// File: rtl/memory_bank_stack_selector_pkg.sv
// Shared defaults and types for the memory bank stack selector.
// Provides the default geometry, the bank index type and the reset bank.
package memory_bank_pkg;

    localparam int unsigned NUM_BANKS_DEF   = 4;
    localparam int unsigned BANK_W_DEF      = 2;
    localparam int unsigned STACK_DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF       = 3;

    typedef logic [BANK_W_DEF-1:0] bank_t;

    localparam bank_t RESET_BANK = '0;

endpackage

// File: rtl/memory_bank_stack_selector_if.sv
// Request/status bundle of the memory bank stack selector.
// master drives write/push/pop/clear requests; slave returns bank, depth, flags.
interface memory_bank_stack_selector_if #(
    parameter int unsigned BANK_W = 2,
    parameter int unsigned CNT_W  = 3
);

    logic              write_en;
    logic [BANK_W-1:0] in_data;
    logic              push_en;
    logic              pop_en;
    logic              clear_err;
    logic [BANK_W-1:0] out_data;
    logic [CNT_W-1:0]  depth;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;
    logic              bad_bank;

    modport master (
        output write_en, in_data, push_en, pop_en, clear_err,
        input  out_data, depth, full, empty,
        input  overflow, underflow, bad_bank
    );

    modport slave (
        input  write_en, in_data, push_en, pop_en, clear_err,
        output out_data, depth, full, empty,
        output overflow, underflow, bad_bank
    );

endinterface

// File: rtl/memory_bank_stack_selector_bank_lifo.sv
// LIFO of saved bank indices with a saturating depth counter.
// Ports: clk, rst_n, push/pop, din, top (entry at depth-1), depth, full, empty.
module bank_lifo #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     top,
    output logic [CNT_W-1:0] depth,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [CNT_W-1:0] depth_q;
    logic [CNT_W-1:0] depth_d;
    logic [CNT_W-1:0] rd_cnt;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign full   = (depth_q == CNT_W'(DEPTH));
    assign empty  = (depth_q == '0);
    assign depth  = depth_q;
    assign rd_cnt = depth_q - CNT_W'(1);
    assign wr_idx = depth_q[AW-1:0];
    assign rd_idx = rd_cnt[AW-1:0];
    assign top    = mem_q[rd_idx];

    // Guards keep depth inside 0..DEPTH even if the caller misbehaves.
    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        if (push && !full) begin
            mem_d[wr_idx] = din;
            depth_d       = depth_q + CNT_W'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/memory_bank_stack_selector.sv
// Current memory bank register with a save/restore stack and sticky errors.
// Ports: clk, rst_n, bus (slave: requests in; bank, depth, full/empty, flags out).
module memory_bank_stack_selector
    import memory_bank_pkg::*;
#(
    parameter int unsigned NUM_BANKS   = NUM_BANKS_DEF,
    parameter int unsigned BANK_W      = BANK_W_DEF,
    parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    memory_bank_stack_selector_if.slave bus
);

    logic [BANK_W-1:0] cur_q;
    logic [BANK_W-1:0] cur_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              bad_bank_q, bad_bank_d;

    logic              push_req, pop_req;
    logic              push_ok, pop_ok;
    logic              wr_valid, wr_bad;
    logic [BANK_W-1:0] lifo_top;
    logic [CNT_W-1:0]  lifo_depth;
    logic              lifo_full, lifo_empty;

    bank_lifo #(
        .W     (BANK_W),
        .DEPTH (STACK_DEPTH),
        .CNT_W (CNT_W)
    ) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop_ok),
        .din   (cur_q),
        .top   (lifo_top),
        .depth (lifo_depth),
        .full  (lifo_full),
        .empty (lifo_empty)
    );

    always_comb begin
        // Simultaneous push and pop cancel: no stack op, no error.
        push_req = bus.push_en & ~bus.pop_en;
        pop_req  = bus.pop_en & ~bus.push_en;
        push_ok  = push_req & ~lifo_full;
        pop_ok   = pop_req & ~lifo_empty;
        wr_valid = bus.write_en & (32'(bus.in_data) < NUM_BANKS);
        // A successful pop swallows the write, including its range check.
        wr_bad   = bus.write_en & ~wr_valid & ~pop_ok;

        cur_d = cur_q;
        if (pop_ok) begin
            cur_d = lifo_top;
        end else if (wr_valid) begin
            cur_d = bus.in_data;
        end

        // New errors win over clear_err in the same cycle.
        overflow_d  = (overflow_q & ~bus.clear_err) | (push_req & lifo_full);
        underflow_d = (underflow_q & ~bus.clear_err) | (pop_req & lifo_empty);
        bad_bank_d  = (bad_bank_q & ~bus.clear_err) | wr_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q       <= BANK_W'(RESET_BANK);
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            bad_bank_q  <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            bad_bank_q  <= bad_bank_d;
        end
    end

    assign bus.out_data  = cur_q;
    assign bus.depth     = lifo_depth;
    assign bus.full      = lifo_full;
    assign bus.empty     = lifo_empty;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.bad_bank  = bad_bank_q;

endmodule

// File: tb/tb_memory_bank_stack_selector.sv
// Self-checking bench: directed literal checks plus random traffic
// compared each cycle against a queue-based model of the bank stack.
module tb_memory_bank_stack_selector;

    localparam int NB = 3;
    localparam int BW = 2;
    localparam int SD = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad_cnt = 0;

    memory_bank_stack_selector_if #(.BANK_W(BW), .CNT_W(CW)) bus ();

    memory_bank_stack_selector #(
        .NUM_BANKS   (NB),
        .BANK_W      (BW),
        .STACK_DEPTH (SD),
        .CNT_W       (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of saved banks and plain flags.
    int m_stk[$];
    int m_cur;
    bit m_ov, m_un, m_bb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stk.delete();
            m_cur = 0;
            m_ov = 0;
            m_un = 0;
            m_bb = 0;
        end else begin
            bit pu, po, we, ce, valid, popped;
            int d, n;
            pu = bus.push_en && !bus.pop_en;
            po = bus.pop_en && !bus.push_en;
            we = bus.write_en;
            ce = bus.clear_err;
            d = int'(bus.in_data);
            n = m_stk.size();
            valid = we && (d < NB);
            popped = po && (n > 0);
            if (ce) begin
                m_ov = 0;
                m_un = 0;
                m_bb = 0;
            end
            if (pu && n == SD) m_ov = 1;
            if (po && n == 0) m_un = 1;
            if (we && !valid && !popped) m_bb = 1;
            if (popped) begin
                m_cur = m_stk.pop_back();
            end else begin
                if (pu && n < SD) m_stk.push_back(m_cur);
                if (valid) m_cur = d;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    bit cmp_on = 0;

    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            chk("m.out_data", int'(bus.out_data), m_cur);
            chk("m.depth", int'(bus.depth), m_stk.size());
            chk("m.full", int'(bus.full), int'(m_stk.size() == SD));
            chk("m.empty", int'(bus.empty), int'(m_stk.size() == 0));
            chk("m.overflow", int'(bus.overflow), int'(m_ov));
            chk("m.underflow", int'(bus.underflow), int'(m_un));
            chk("m.bad_bank", int'(bus.bad_bank), int'(m_bb));
        end
    end

    task automatic step(input bit we, input int d, input bit pu,
                        input bit po, input bit ce);
        bus.write_en = we;
        bus.in_data = BW'(d);
        bus.push_en = pu;
        bus.pop_en = po;
        bus.clear_err = ce;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all(input string tag, input int o, input int dp,
                           input int ov, input int un, input int bb);
        chk({tag, ".out"}, int'(bus.out_data), o);
        chk({tag, ".depth"}, int'(bus.depth), dp);
        chk({tag, ".full"}, int'(bus.full), int'(dp == SD));
        chk({tag, ".empty"}, int'(bus.empty), int'(dp == 0));
        chk({tag, ".ovf"}, int'(bus.overflow), ov);
        chk({tag, ".unf"}, int'(bus.underflow), un);
        chk({tag, ".bad"}, int'(bus.bad_bank), bb);
    endtask

    initial begin
        bus.write_en = 0;
        bus.in_data = '0;
        bus.push_en = 0;
        bus.pop_en = 0;
        bus.clear_err = 0;
        repeat (2) @(posedge clk);
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
        rst_n = 1;
        cmp_on = 1;

        step(1, 2, 0, 0, 0);
        chk_all("wr2", 2, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        chk_all("call", 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk_all("ret", 2, 0, 0, 0, 0);

        for (int i = 0; i < SD; i++) step(0, 0, 1, 0, 0);
        chk_all("fill", 2, 4, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_all("ovf", 2, 4, 1, 0, 0);
        for (int i = 0; i < SD; i++) begin
            step(0, 0, 0, 1, 0);
            chk("drain.out", int'(bus.out_data), 2);
            chk("drain.depth", int'(bus.depth), SD - 1 - i);
        end
        step(0, 0, 0, 1, 0);
        chk_all("unf", 2, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1);
        chk_all("clr", 2, 0, 0, 0, 0);

        step(1, 3, 0, 0, 0);
        chk_all("badwr", 2, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        chk_all("wr0", 0, 0, 0, 0, 1);
        step(1, 3, 0, 0, 1);
        chk_all("setwins", 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        step(1, 2, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        chk_all("d1", 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        chk_all("popwr", 2, 0, 0, 0, 0);
        step(1, 3, 0, 1, 0);
        chk_all("unfwr", 2, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        step(1, 1, 1, 1, 0);
        chk_all("pupo", 1, 1, 0, 0, 0);
        step(1, 3, 1, 1, 0);
        chk_all("pupobad", 1, 1, 0, 0, 1);

        step(1, 0, 1, 0, 0);
        chk_all("d2", 0, 2, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        chk_all("d2b", 1, 2, 0, 0, 1);
        #1 rst_n = 0;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0);
        step(1, 2, 1, 0, 0);
        chk_all("held_rst", 0, 0, 0, 0, 0);
        #1 rst_n = 1;

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 3),
                 ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 19) == 0));
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        cmp_on = 0;

        $display("test done: total=%0d bad=%0d", total, bad_cnt);
        $finish;
    end

endmodule
